l1_tlb: RTL

//  Per-port first-level TLB; the query initiator for the 64-entry l2_tlb.

---
 rtl/l1_tlb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/l1_tlb.sv
// Per-port first-level TLB: small fully-associative entry cache in front of l2_tlb,
// with kseg0/kseg1 bypass, miss handling through a one-shot L2 query, and exception flags.
module l1_tlb #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_en,
   input  logic [31:0] req_vaddr,
   input  logic        req_wr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_paddr,
   output logic [2:0]  resp_cache,
   output logic        resp_refill,
   output logic        resp_invalid,
   output logic        resp_modified,
   input  logic [7:0]  cp0_asid,
   input  logic        flush,
   output logic        l2_qry_en,
   output logic [31:0] l2_qry_vaddr,
   input  logic [78:0] l2_qry_tlb,
   input  logic        l2_qry_isexist,
   input  logic        l2_qry_done
);

   localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {IDLE, QRY, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [78:0]       tlb [ENTRIES];
   logic [ENTRIES-1:0] valid;
   logic [IDXW-1:0]   rr;
   logic [31:0]       lat_vaddr;
   logic              lat_wr;
   logic              discard;

   logic              bypass;
   logic              hit;
   logic [IDXW-1:0]   hit_idx;
   logic              match;
   logic [IDXW-1:0]   match_idx;
   logic [IDXW-1:0]   fill_idx;
   logic              fill_en;
   logic [24:0]       hit_half;
   logic [24:0]       fill_half;

   assign bypass       = (req_vaddr[31:30] == 2'b10);
   assign req_ready    = (state == IDLE);
   assign l2_qry_en    = (state == QRY);
   assign l2_qry_vaddr = lat_vaddr;

   // Page-half fields packed as {pfn[24:5], c[4:2], d[1], v[0]}; the G bit is dropped.
   assign hit_half  = req_vaddr[12] ? tlb[hit_idx][51:27] : tlb[hit_idx][25:1];
   assign fill_half = lat_vaddr[12] ? l2_qry_tlb[51:27] : l2_qry_tlb[25:1];

   // A result arriving with (or after) a flush in WAIT is stale and must not be cached.
   assign fill_en  = (state == WAIT) && l2_qry_done && l2_qry_isexist && !discard && !flush;
   assign fill_idx = match ? match_idx : rr;

   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      match     = 1'b0;
      match_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && (tlb[i][78:60] == req_vaddr[31:13]) &&
             ((tlb[i][0] && tlb[i][26]) || (tlb[i][59:52] == cp0_asid))) begin
            hit     = 1'b1;
            hit_idx = IDXW'(i);
         end
         if (valid[i] && (tlb[i][78:52] == l2_qry_tlb[78:52])) begin
            match     = 1'b1;
            match_idx = IDXW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_en && !bypass && !hit) state_nxt = QRY;
         QRY:  state_nxt = WAIT;
         WAIT: if (l2_qry_done) state_nxt = (discard || flush) ? QRY : RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tlb[fill_idx] <= l2_qry_tlb;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid         <= '0;
         rr            <= '0;
         lat_vaddr     <= '0;
         lat_wr        <= 1'b0;
         discard       <= 1'b0;
         resp_valid    <= 1'b0;
         resp_paddr    <= '0;
         resp_cache    <= '0;
         resp_refill   <= 1'b0;
         resp_invalid  <= 1'b0;
         resp_modified <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (flush) begin
            valid <= '0;
         end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
         end
         // Refreshing an already-cached translation in place does not consume a victim slot.
         if (fill_en && !match) begin
            rr <= (rr == IDXW'(ENTRIES - 1)) ? '0 : rr + 1'b1;
         end
         case (state)
            IDLE: begin
               if (req_en) begin
                  if (bypass) begin
                     resp_valid    <= 1'b1;
                     resp_paddr    <= {3'b000, req_vaddr[28:0]};
                     resp_cache    <= req_vaddr[29] ? 3'd2 : 3'd3;
                     resp_refill   <= 1'b0;
                     resp_invalid  <= 1'b0;
                     resp_modified <= 1'b0;
                  end else if (hit) begin
                     resp_valid    <= 1'b1;
                     resp_paddr    <= {hit_half[24:5], req_vaddr[11:0]};
                     resp_cache    <= hit_half[4:2];
                     resp_refill   <= 1'b0;
                     resp_invalid  <= ~hit_half[0];
                     resp_modified <= hit_half[0] & req_wr & ~hit_half[1];
                  end else begin
                     lat_vaddr <= req_vaddr;
                     lat_wr    <= req_wr;
                  end
               end
            end
            WAIT: begin
               if (l2_qry_done) begin
                  discard <= 1'b0;
                  if (!discard && !flush) begin
                     resp_valid <= 1'b1;
                     if (l2_qry_isexist) begin
                        resp_paddr    <= {fill_half[24:5], lat_vaddr[11:0]};
                        resp_cache    <= fill_half[4:2];
                        resp_refill   <= 1'b0;
                        resp_invalid  <= ~fill_half[0];
                        resp_modified <= fill_half[0] & lat_wr & ~fill_half[1];
                     end else begin
                        resp_paddr    <= '0;
                        resp_cache    <= '0;
                        resp_refill   <= 1'b1;
                        resp_invalid  <= 1'b0;
                        resp_modified <= 1'b0;
                     end
                  end
               end else if (flush) begin
                  discard <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
